// File: rtl/conv_scan_pkg.sv
// Shared widths and FSM state codes for the convolution raster scanner.
package conv_scan_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_MAT_W  = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/conv_scan_counter.sv
// Row/column/linear-index counter for a square N x N raster, wrapping columns at N.
module scan_counter
    import conv_scan_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int MAT_W  = DEF_MAT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              enable,
    input  logic [MAT_W-1:0]  n,
    output logic [ADDR_W-1:0] cnt,
    output logic [MAT_W-1:0]  r,
    output logic [MAT_W-1:0]  c
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            r   <= '0;
            c   <= '0;
        end else if (clear) begin
            cnt <= '0;
            r   <= '0;
            c   <= '0;
        end else if (enable) begin
            cnt <= cnt + ADDR_W'(1);
            if (c == n - MAT_W'(1)) begin
                c <= '0;
                r <= r + MAT_W'(1);
            end else begin
                c <= c + MAT_W'(1);
            end
        end
    end

endmodule

// File: rtl/conv_scan.sv
// Raster scanner: emits pixel indices 0..N*N-1 of an N x N feature map under ready backpressure.
module conv_scan
    import conv_scan_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int MAT_W  = DEF_MAT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [MAT_W-1:0]  matrix,
    input  logic              ready,
    output logic              go,
    output logic [ADDR_W-1:0] i,
    output logic [MAT_W-1:0]  row,
    output logic [MAT_W-1:0]  col,
    output logic              last,
    output logic              busy,
    output logic              done
);

    logic [1:0]          state;
    logic [MAT_W-1:0]    n_lat;
    logic [ADDR_W-1:0]   total;
    logic [ADDR_W-1:0]   cnt;
    logic [MAT_W-1:0]    r;
    logic [MAT_W-1:0]    c;
    logic [2*MAT_W-1:0]  sq;
    logic                clear;
    logic                issue;

    // The only multiply; it is consumed once, in LOAD.
    assign sq    = {{MAT_W{1'b0}}, matrix} * {{MAT_W{1'b0}}, matrix};
    assign clear = (state == ST_LOAD);
    // While last is presented the scan is finished, so nothing more may issue.
    assign issue = (state == ST_RUN) && ready && !last;
    assign busy  = (state != ST_IDLE);
    assign done  = (state == ST_DONE);

    scan_counter #(
        .ADDR_W (ADDR_W),
        .MAT_W  (MAT_W)
    ) u_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .enable (issue),
        .n      (n_lat),
        .cnt    (cnt),
        .r      (r),
        .c      (c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            n_lat <= '0;
            total <= '0;
            go    <= 1'b0;
            last  <= 1'b0;
            i     <= '0;
            row   <= '0;
            col   <= '0;
        end else begin
            go   <= 1'b0;
            last <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    n_lat <= matrix;
                    total <= sq[ADDR_W-1:0];
                    i     <= '0;
                    row   <= '0;
                    col   <= '0;
                    state <= (matrix == '0) ? ST_DONE : ST_RUN;
                end
                ST_RUN: begin
                    // Leave one cycle after the final index so done trails the last go.
                    if (last) begin
                        state <= ST_DONE;
                    end else if (ready) begin
                        go   <= 1'b1;
                        i    <= cnt;
                        row  <= r;
                        col  <= c;
                        last <= (cnt == total - ADDR_W'(1));
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_scan.sv
// Directed self-checking bench for conv_scan: full scans, backpressure, edge sizes, reset and busy-time disturbance.
module tb_conv_scan;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] matrix;
    logic       ready;
    logic       go;
    logic [9:0] i;
    logic [4:0] row;
    logic [4:0] col;
    logic       last;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    conv_scan dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .matrix (matrix),
        .ready  (ready),
        .go     (go),
        .i      (i),
        .row    (row),
        .col    (col),
        .last   (last),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One complete scan of an n x n map; toggle alternates ready, disturb pokes start/matrix mid-scan.
    task automatic run_scan(input int n, input bit toggle, input bit disturb);
        int total;
        int exp_idx;
        int last_go_cyc;
        int cyc;
        bit prev_ready;
        bit finished;
        logic [9:0] held_i;
        total       = n * n;
        exp_idx     = 0;
        last_go_cyc = -10;
        finished    = 1'b0;
        held_i      = '0;
        $display("[TB] scan N=%0d toggle=%0d disturb=%0d", n, toggle, disturb);
        matrix = 5'(n);
        start  = 1'b1;
        ready  = 1'b1;
        tick();
        start = 1'b0;
        check_output("busy_in_load", 32'(busy), 32'd1);
        check_output("go_in_load", 32'(go), 32'd0);
        for (cyc = 1; cyc <= 4 * total + 20 && !finished; cyc++) begin
            prev_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            ready = prev_ready;
            if (disturb && cyc == 3) begin
                start  = 1'b1;
                matrix = 5'd7;
            end
            tick();
            if (go) begin
                check_output("ready_before_go", 32'(prev_ready), 32'd1);
                check_output("idx", 32'(i), 32'(exp_idx));
                check_output("row", 32'(row), 32'(exp_idx / n));
                check_output("col", 32'(col), 32'(exp_idx % n));
                check_output("last", 32'(last), 32'(exp_idx == total - 1));
                held_i      = i;
                last_go_cyc = cyc;
                exp_idx++;
            end else if (!prev_ready && exp_idx > 0) begin
                check_output("hold_i", 32'(i), 32'(held_i));
                check_output("no_last_on_stall", 32'(last), 32'd0);
            end
            if (done) begin
                check_output("go_count", 32'(exp_idx), 32'(total));
                check_output("go_in_done", 32'(go), 32'd0);
                check_output("busy_in_done", 32'(busy), 32'd1);
                if (n == 0)
                    check_output("n0_done_latency", 32'(cyc), 32'd1);
                else
                    check_output("done_after_last", 32'(cyc - last_go_cyc), 32'd1);
                start    = 1'b0;
                matrix   = 5'(n);
                finished = 1'b1;
            end
        end
        check_output("done_seen", 32'(finished), 32'd1);
        tick();
        check_output("busy_after_done", 32'(busy), 32'd0);
        check_output("done_one_cycle", 32'(done), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_output("idle_go", 32'(go), 32'd0);
            check_output("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        bit seen5;
        rst_n  = 1'b0;
        start  = 1'b0;
        matrix = '0;
        ready  = 1'b0;
        #12;
        check_output("rst_go", 32'(go), 32'd0);
        check_output("rst_i", 32'(i), 32'd0);
        check_output("rst_row", 32'(row), 32'd0);
        check_output("rst_col", 32'(col), 32'd0);
        check_output("rst_last", 32'(last), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_output("idle_no_start", 32'(busy), 32'd0);
        end

        run_scan(3, 1'b0, 1'b0);
        run_scan(4, 1'b1, 1'b0);
        run_scan(1, 1'b0, 1'b0);
        run_scan(0, 1'b0, 1'b0);
        run_scan(31, 1'b0, 1'b0);

        // Asynchronous reset while index 5 of a 4x4 scan is on the outputs.
        $display("[TB] mid-scan reset");
        matrix = 5'd4;
        ready  = 1'b1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        seen5 = 1'b0;
        for (int k = 0; k < 20 && !seen5; k++) begin
            tick();
            if (go && i == 10'd5) seen5 = 1'b1;
        end
        check_output("reached_i5", 32'(seen5), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("arst_go", 32'(go), 32'd0);
        check_output("arst_i", 32'(i), 32'd0);
        check_output("arst_row", 32'(row), 32'd0);
        check_output("arst_col", 32'(col), 32'd0);
        check_output("arst_busy", 32'(busy), 32'd0);
        check_output("arst_done", 32'(done), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_output("post_rst_go", 32'(go), 32'd0);
            check_output("post_rst_busy", 32'(busy), 32'd0);
        end
        run_scan(4, 1'b0, 1'b0);

        run_scan(4, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
